// File: rtl/ysyx_22041211_lsu_wb.sv
// Memory-access / writeback stage: one instruction in flight, valid/ready memory bus, registered outputs.
// Optional misaligned-access trap enabled by defining YSYX_22041211_LSU_MISALIGN_CHECK_EN.
module ysyx_22041211_lsu_wb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  wb_reg_write,
    output logic                  misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t state_q, next_state;

    logic                  op_is_load, op_is_store;
    logic [2:0]            op_funct3;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] op_store_data;
    logic [4:0]            op_rd;
    logic                  capture;

    logic                  src_is_load, src_is_store;
    logic [2:0]            src_funct3;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_data;
    logic [3:0]            lane_mask;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] load_shift, load_ext;

    logic                  in_ready_d, req_valid_d, req_wen_d, wb_valid_d, wb_rw_d;
    logic [ADDR_WIDTH-1:0] req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_d, wb_wdata_d;
    logic [3:0]            req_wmask_d;
    logic [4:0]            wb_rd_d;

`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
    logic mis_c, misalign_d;
    always_comb begin
        mis_c = ((in_funct3[1:0] == 2'b01) && in_addr[0])
             || ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    end
`else
    assign misalign = 1'b0;
`endif

    // Request source: live inputs when issuing from IDLE, latched fields while holding in REQ.
    always_comb begin
        if (state_q == IDLE) begin
            src_is_load  = in_is_load;
            src_is_store = in_is_store;
            src_funct3   = in_funct3;
            src_addr     = in_addr;
            src_data     = in_store_data;
        end else begin
            src_is_load  = op_is_load;
            src_is_store = op_is_store;
            src_funct3   = op_funct3;
            src_addr     = op_addr;
            src_data     = op_store_data;
        end
    end

    // Store byte lanes; mask bits shifted past bit 3 fall off.
    always_comb begin
        case (src_funct3[1:0])
            2'b00: begin
                lane_mask  = 4'(4'b0001 << src_addr[1:0]);
                lane_wdata = DATA_WIDTH'({4{src_data[7:0]}});
            end
            2'b01: begin
                lane_mask  = 4'(4'b0011 << src_addr[1:0]);
                lane_wdata = DATA_WIDTH'({2{src_data[15:0]}});
            end
            default: begin
                lane_mask  = 4'b1111;
                lane_wdata = src_data;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        load_shift = mem_resp_rdata >> {op_addr[1:0], 3'b000};
        case (op_funct3)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, load_shift[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    // Next state and next-cycle output values.
    always_comb begin
        next_state  = state_q;
        capture     = 1'b0;
        in_ready_d  = 1'b0;
        req_valid_d = 1'b0;
        req_addr_d  = '0;
        req_wen_d   = 1'b0;
        req_wdata_d = '0;
        req_wmask_d = '0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = '0;
        wb_wdata_d  = '0;
        wb_rw_d     = 1'b0;
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    capture = 1'b1;
                    if (in_is_load || in_is_store) begin
                        next_state = REQ;
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
                        if (mis_c) begin
                            next_state = WB;
                            wb_valid_d = 1'b1;
                            wb_rd_d    = in_rd;
                            misalign_d = 1'b1;
                        end
`endif
                    end else begin
                        next_state = WB;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_wdata_d = DATA_WIDTH'(in_addr);
                        wb_rw_d    = in_reg_write && (in_rd != 5'd0);
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            REQ: begin
                if (mem_req_valid && mem_req_ready) next_state = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    next_state = WB;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = op_rd;
                    if (op_is_load) begin
                        wb_wdata_d = load_ext;
                        wb_rw_d    = (op_rd != 5'd0);
                    end
                end
            end
            WB: begin
                next_state = IDLE;
                in_ready_d = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        if (next_state == REQ) begin
            req_valid_d = 1'b1;
            req_addr_d  = {src_addr[ADDR_WIDTH-1:2], 2'b00};
            req_wen_d   = src_is_store && !src_is_load;
            req_wdata_d = lane_wdata;
            req_wmask_d = lane_mask;
        end
    end

    // State, latched instruction and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_is_load    <= 1'b0;
            op_is_store   <= 1'b0;
            op_funct3     <= '0;
            op_addr       <= '0;
            op_store_data <= '0;
            op_rd         <= '0;
            in_ready      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_wdata      <= '0;
            wb_reg_write  <= 1'b0;
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
            misalign      <= 1'b0;
`endif
        end else begin
            state_q       <= next_state;
            if (capture) begin
                op_is_load    <= in_is_load;
                op_is_store   <= in_is_store;
                op_funct3     <= in_funct3;
                op_addr       <= in_addr;
                op_store_data <= in_store_data;
                op_rd         <= in_rd;
            end
            in_ready      <= in_ready_d;
            mem_req_valid <= req_valid_d;
            mem_req_addr  <= req_addr_d;
            mem_req_wen   <= req_wen_d;
            mem_req_wdata <= req_wdata_d;
            mem_req_wmask <= req_wmask_d;
            wb_valid      <= wb_valid_d;
            wb_rd         <= wb_rd_d;
            wb_wdata      <= wb_wdata_d;
            wb_reg_write  <= wb_rw_d;
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
            misalign      <= misalign_d;
`endif
        end
    end

endmodule
